// File: rtl/line_draw_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : line_draw_engine_pkg
// Purpose  : Shared state encoding and address-field constants for the line
//            draw engine.
// Revision : 1.0
// ============================================================================
package line_draw_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PLOT  = 3'd2,
    ST_SEND1 = 3'd3,
    ST_SEND2 = 3'd4
  } state_t;

  localparam logic [1:0] c_addr_pad = 2'b00;
  localparam int         c_frame_hi = 27;
  localparam int         c_frame_lo = 22;
  localparam int         c_frame_w  = c_frame_hi - c_frame_lo + 1;

endpackage
`default_nettype wire

// File: rtl/line_draw_engine_setup.sv
`default_nettype none
// ============================================================================
// Module   : line_setup_calc
// Purpose  : Combinational Bresenham setup: steep test, endpoint swap/order,
//            deltas, step direction and initial error term.
// Revision : 1.0
// ============================================================================
module line_setup_calc #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0]        i_x0,
  input  logic [COORD_W-1:0]        i_y0,
  input  logic [COORD_W-1:0]        i_x1,
  input  logic [COORD_W-1:0]        i_y1,
  output logic                      o_steep,
  output logic [COORD_W-1:0]        o_nx0,
  output logic [COORD_W-1:0]        o_ny0,
  output logic [COORD_W-1:0]        o_nx1,
  output logic [COORD_W-1:0]        o_dx,
  output logic [COORD_W-1:0]        o_dy,
  output logic                      o_ystep_neg,
  output logic signed [COORD_W:0]   o_err_init
);

  logic [COORD_W-1:0] w_adx, w_ady;
  logic [COORD_W-1:0] w_sx0, w_sy0, w_sx1, w_sy1, w_ny1;
  logic               w_swap;

  always_comb begin
    w_adx   = (i_x1 >= i_x0) ? i_x1 - i_x0 : i_x0 - i_x1;
    w_ady   = (i_y1 >= i_y0) ? i_y1 - i_y0 : i_y0 - i_y1;
    o_steep = w_ady > w_adx;

    // Transpose steep lines so x is always the major axis
    w_sx0 = o_steep ? i_y0 : i_x0;
    w_sy0 = o_steep ? i_x0 : i_y0;
    w_sx1 = o_steep ? i_y1 : i_x1;
    w_sy1 = o_steep ? i_x1 : i_y1;

    w_swap = w_sx0 > w_sx1;
    o_nx0  = w_swap ? w_sx1 : w_sx0;
    o_ny0  = w_swap ? w_sy1 : w_sy0;
    o_nx1  = w_swap ? w_sx0 : w_sx1;
    w_ny1  = w_swap ? w_sy0 : w_sy1;

    o_dx        = o_nx1 - o_nx0;
    o_ystep_neg = w_ny1 < o_ny0;
    o_dy        = o_ystep_neg ? o_ny0 - w_ny1 : w_ny1 - o_ny0;
    o_err_init  = $signed({2'b00, o_dx[COORD_W-1:1]});
  end

endmodule
`default_nettype wire

// File: rtl/line_draw_engine.sv
`default_nettype none
// ============================================================================
// Module   : line_draw_engine
// Purpose  : Bresenham line rasteriser emitting 8-pixel coalesced two-beat
//            write bursts into address / write-data FIFOs.
// Revision : 1.0
// ============================================================================
module line_draw_engine
  import line_draw_engine_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 31
) (
  input  logic               clk,
  input  logic               rst,
  output logic               LE_ready,
  input  logic [31:0]        LE_color,
  input  logic [COORD_W-1:0] LE_point,
  input  logic               LE_color_valid,
  input  logic               LE_x0_valid,
  input  logic               LE_y0_valid,
  input  logic               LE_x1_valid,
  input  logic               LE_y1_valid,
  input  logic [31:0]        LE_frame_base,
  input  logic               LE_trigger,
  input  logic               af_full,
  input  logic               wdf_full,
  output logic [ADDR_W-1:0]  af_addr_din,
  output logic               af_wr_en,
  output logic [127:0]       wdf_din,
  output logic [15:0]        wdf_mask_din,
  output logic               wdf_wr_en
);

  localparam logic [COORD_W-1:0] c_one = COORD_W'(1);

  state_t                   r_state, w_next;
  logic [COORD_W-1:0]       r_x0, r_y0, r_x1, r_y1;
  logic [31:0]              r_color;
  logic [c_frame_w-1:0]     r_frame;
  logic                     r_steep, r_ystep_neg, r_last;
  logic [COORD_W-1:0]       r_nx1, r_dx, r_dy, r_x, r_y;
  logic signed [COORD_W:0]  r_err;
  logic [7:0]               r_mask;
  logic [ADDR_W-1:0]        r_addr;

  logic                     w_steep, w_ystep_neg;
  logic [COORD_W-1:0]       w_nx0, w_ny0, w_nx1, w_dx, w_dy;
  logic signed [COORD_W:0]  w_err_init, w_err_sub, w_err_next;
  logic [COORD_W-1:0]       w_col, w_row, w_x_next, w_y_next, w_ncol, w_nrow;
  logic                     w_at_end, w_same_blk;
  logic [ADDR_W-1:0]        w_cur_addr;
  logic [31:0]              w_mask32;
  logic                     w_unused;

  function automatic logic [ADDR_W-1:0] f_blk_addr(
    input logic [c_frame_w-1:0] frame,
    input logic [COORD_W-1:0]   col,
    input logic [COORD_W-1:0]   row
  );
    return ADDR_W'({frame, row, col[COORD_W-1:3], c_addr_pad});
  endfunction

  line_setup_calc #(.COORD_W(COORD_W)) u_setup (
    .i_x0        (r_x0),
    .i_y0        (r_y0),
    .i_x1        (r_x1),
    .i_y1        (r_y1),
    .o_steep     (w_steep),
    .o_nx0       (w_nx0),
    .o_ny0       (w_ny0),
    .o_nx1       (w_nx1),
    .o_dx        (w_dx),
    .o_dy        (w_dy),
    .o_ystep_neg (w_ystep_neg),
    .o_err_init  (w_err_init)
  );

  // Current pixel, and the pixel one Bresenham step ahead for block lookahead
  always_comb begin
    w_col      = r_steep ? r_y : r_x;
    w_row      = r_steep ? r_x : r_y;
    w_at_end   = (r_x == r_nx1);
    w_err_sub  = r_err - $signed({1'b0, r_dy});
    w_err_next = w_err_sub;
    w_y_next   = r_y;
    if (w_err_sub[COORD_W]) begin
      w_err_next = w_err_sub + $signed({1'b0, r_dx});
      w_y_next   = r_ystep_neg ? r_y - c_one : r_y + c_one;
    end
    w_x_next   = r_x + c_one;
    w_ncol     = r_steep ? w_y_next : w_x_next;
    w_nrow     = r_steep ? w_x_next : w_y_next;
    w_cur_addr = f_blk_addr(r_frame, w_col, w_row);
    w_same_blk = (f_blk_addr(r_frame, w_ncol, w_nrow) == w_cur_addr);
  end

  always_comb begin
    w_mask32 = '0;
    for (int k = 0; k < 8; k++) w_mask32[31-4*k -: 4] = {4{r_mask[k]}};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    af_wr_en     = 1'b0;
    wdf_wr_en    = 1'b0;
    wdf_mask_din = 16'hFFFF;
    unique case (r_state)
      ST_IDLE:  if (LE_trigger) w_next = ST_SETUP;
      ST_SETUP: w_next = ST_PLOT;
      ST_PLOT:  if (w_at_end || !w_same_blk) w_next = ST_SEND1;
      ST_SEND1: begin
        wdf_mask_din = ~w_mask32[31:16];
        if (!af_full && !wdf_full) begin
          af_wr_en  = 1'b1;
          wdf_wr_en = 1'b1;
          w_next    = ST_SEND2;
        end
      end
      ST_SEND2: begin
        wdf_mask_din = ~w_mask32[15:0];
        if (!wdf_full) begin
          wdf_wr_en = 1'b1;
          w_next    = r_last ? ST_IDLE : ST_PLOT;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x0 <= '0; r_y0 <= '0; r_x1 <= '0; r_y1 <= '0;
      r_color <= '0; r_frame <= '0;
      r_steep <= 1'b0; r_ystep_neg <= 1'b0; r_last <= 1'b0;
      r_nx1 <= '0; r_dx <= '0; r_dy <= '0; r_x <= '0; r_y <= '0;
      r_err <= '0; r_mask <= '0; r_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (LE_color_valid) r_color <= LE_color;
          if (LE_x0_valid)    r_x0    <= LE_point;
          if (LE_y0_valid)    r_y0    <= LE_point;
          if (LE_x1_valid)    r_x1    <= LE_point;
          if (LE_y1_valid)    r_y1    <= LE_point;
          if (LE_trigger)     r_frame <= LE_frame_base[c_frame_hi:c_frame_lo];
        end
        ST_SETUP: begin
          r_steep     <= w_steep;
          r_nx1       <= w_nx1;
          r_dx        <= w_dx;
          r_dy        <= w_dy;
          r_ystep_neg <= w_ystep_neg;
          r_err       <= w_err_init;
          r_x         <= w_nx0;
          r_y         <= w_ny0;
          r_mask      <= '0;
        end
        ST_PLOT: begin
          r_mask[w_col[2:0]] <= 1'b1;
          r_addr             <= w_cur_addr;
          r_last             <= w_at_end;
          if (!w_at_end) begin
            r_x   <= w_x_next;
            r_y   <= w_y_next;
            r_err <= w_err_next;
          end
        end
        ST_SEND2: if (!wdf_full && !r_last) r_mask <= '0;
        default: ;
      endcase
    end
  end

  assign LE_ready    = (r_state == ST_IDLE);
  assign af_addr_din = r_addr;
  assign wdf_din     = {4{r_color}};
  assign w_unused    = ^{LE_frame_base[31:c_frame_hi+1], LE_frame_base[c_frame_lo-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_line_draw_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_draw_engine
// Purpose  : Self-checking bench: directed lines plus random lines against a
//            pixel-list reference model with random FIFO backpressure.
// Revision : 1.0
// ============================================================================
module tb_line_draw_engine;

  localparam int CW = 10;
  localparam int AW = 31;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          LE_ready;
  logic [31:0]   LE_color = '0;
  logic [CW-1:0] LE_point = '0;
  logic          LE_color_valid = 1'b0, LE_x0_valid = 1'b0, LE_y0_valid = 1'b0;
  logic          LE_x1_valid = 1'b0, LE_y1_valid = 1'b0;
  logic [31:0]   LE_frame_base = '0;
  logic          LE_trigger = 1'b0, af_full = 1'b0, wdf_full = 1'b0;
  logic [AW-1:0] af_addr_din;
  logic          af_wr_en, wdf_wr_en;
  logic [127:0]  wdf_din;
  logic [15:0]   wdf_mask_din;

  typedef struct { logic first; logic [AW-1:0] addr; logic [15:0] mask; logic [127:0] din; } beat_t;
  typedef struct { logic [AW-1:0] addr; logic [15:0] m1; logic [15:0] m2; } burst_t;

  beat_t  beats[$];
  burst_t exp_q[$];
  int     af_only = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     lat;
  bit     tmo;

  line_draw_engine #(.COORD_W(CW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .LE_ready(LE_ready), .LE_color(LE_color), .LE_point(LE_point),
    .LE_color_valid(LE_color_valid), .LE_x0_valid(LE_x0_valid), .LE_y0_valid(LE_y0_valid),
    .LE_x1_valid(LE_x1_valid), .LE_y1_valid(LE_y1_valid), .LE_frame_base(LE_frame_base),
    .LE_trigger(LE_trigger), .af_full(af_full), .wdf_full(wdf_full),
    .af_addr_din(af_addr_din), .af_wr_en(af_wr_en), .wdf_din(wdf_din),
    .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wdf_wr_en) beats.push_back('{af_wr_en, af_addr_din, wdf_mask_din, wdf_din});
    else if (af_wr_en) af_only++;
  end

  // ---------------- reference model: pixel list -> coalesced bursts ----------
  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [15:0] half_mask(input logic [7:0] pm, input int first_px);
    logic [15:0] m;
    for (int k = 0; k < 4; k++) m[15-4*k -: 4] = {4{~pm[first_px+k]}};
    return m;
  endfunction

  task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input logic [31:0] base);
    int x0, y0, x1, y1, t, dx, dy, err, ys, y, col, row, fr;
    bit steep, open;
    logic [AW-1:0] a, cur_a;
    logic [7:0] pm;
    x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
    exp_q.delete();
    steep = iabs(y1 - y0) > iabs(x1 - x0);
    if (steep) begin t = x0; x0 = y0; y0 = t; t = x1; x1 = y1; y1 = t; end
    if (x0 > x1) begin t = x0; x0 = x1; x1 = t; t = y0; y0 = y1; y1 = t; end
    dx = x1 - x0; dy = iabs(y1 - y0); err = dx / 2; ys = (y0 < y1) ? 1 : -1;
    y = y0; open = 0; pm = '0; cur_a = '0;
    fr = int'(base[27:22]);
    for (int x = x0; x <= x1; x++) begin
      col = steep ? y : x;
      row = steep ? x : y;
      a = AW'(fr * (2 ** (2*CW-1)) + row * (2 ** (CW-1)) + (col / 8) * 4);
      if (open && a != cur_a) begin
        exp_q.push_back('{cur_a, half_mask(pm, 0), half_mask(pm, 4)});
        pm = '0;
      end
      open = 1; cur_a = a; pm[col % 8] = 1'b1;
      err -= dy;
      if (err < 0) begin y += ys; err += dx; end
    end
    exp_q.push_back('{cur_a, half_mask(pm, 0), half_mask(pm, 4)});
  endtask

  // ---------------- stimulus helpers ----------------------------------------
  task automatic start_line(input int x0, input int y0, input int x1, input int y1,
                            input logic [31:0] color, input logic [31:0] base);
    @(posedge clk); #1;
    LE_point = CW'(x0); LE_x0_valid = 1; LE_color = color; LE_color_valid = 1;
    @(posedge clk); #1;
    LE_x0_valid = 0; LE_color_valid = 0; LE_point = CW'(y0); LE_y0_valid = 1;
    @(posedge clk); #1;
    LE_y0_valid = 0; LE_point = CW'(x1); LE_x1_valid = 1;
    @(posedge clk); #1;
    LE_x1_valid = 0; LE_point = CW'(y1); LE_y1_valid = 1; LE_frame_base = base; LE_trigger = 1;
    @(posedge clk); #1;
    LE_y1_valid = 0; LE_trigger = 0;
    LE_color = $urandom; LE_frame_base = $urandom; LE_point = CW'($urandom);
  endtask

  task automatic wait_idle(input bit noisy, output int latency, output bit timeout);
    int cyc;
    cyc = 0; latency = -1; timeout = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (af_wr_en && latency < 0) latency = cyc;
      if (LE_ready) break;
      if (cyc > 20000) begin timeout = 1; break; end
      if (noisy) begin
        @(posedge clk); #1;
        af_full    = ($urandom_range(0, 3) == 0);
        wdf_full   = ($urandom_range(0, 3) == 0);
        LE_trigger = ($urandom_range(0, 7) == 0);
        {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid} = 5'($urandom);
        LE_point = CW'($urandom); LE_color = $urandom;
      end
    end
    af_full = 0; wdf_full = 0; LE_trigger = 0;
    {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid} = '0;
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (LE_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", LE_ready); end
    n_cmp++; if ({af_wr_en, wdf_wr_en} !== 2'b00) begin n_bad++; $display("FAIL reset_wr_en got=%b want=00", {af_wr_en, wdf_wr_en}); end
    n_cmp++; if (wdf_mask_din !== 16'hFFFF) begin n_bad++; $display("FAIL reset_mask got=%h want=ffff", wdf_mask_din); end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_horizontal(input bit reverse);
    beats.delete();
    if (reverse) start_line(7, 0, 0, 0, 32'h00FF0000, 32'h10400000);
    else         start_line(0, 0, 7, 0, 32'h00FF0000, 32'h10400000);
    wait_idle(0, lat, tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL horiz_timeout rev=%0d", reverse); end
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL horiz_latency rev=%0d got=%0d want=10", reverse, lat); end
    n_cmp++;
    if (beats.size() != 2) begin
      n_bad++; $display("FAIL horiz_beats rev=%0d got=%0d want=2", reverse, beats.size());
    end else begin
      n_cmp++; if (beats[0].first !== 1'b1 || beats[0].addr !== 31'h80000) begin n_bad++; $display("FAIL horiz_addr rev=%0d got=%h want=80000", reverse, beats[0].addr); end
      n_cmp++; if (beats[0].mask !== 16'h0000) begin n_bad++; $display("FAIL horiz_mask1 rev=%0d got=%h want=0000", reverse, beats[0].mask); end
      n_cmp++; if (beats[1].first !== 1'b0 || beats[1].mask !== 16'h0000) begin n_bad++; $display("FAIL horiz_mask2 rev=%0d got=%h want=0000", reverse, beats[1].mask); end
      n_cmp++; if (beats[0].din !== {4{32'h00FF0000}} || beats[1].din !== {4{32'h00FF0000}}) begin n_bad++; $display("FAIL horiz_data rev=%0d got=%h want=4x00ff0000", reverse, beats[0].din); end
    end
  endtask

  task automatic test_point();
    beats.delete();
    start_line(3, 5, 3, 5, 32'h00ABCDEF, 32'h10400000);
    wait_idle(0, lat, tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL point_timeout"); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL point_latency got=%0d want=3", lat); end
    n_cmp++;
    if (beats.size() != 2) begin
      n_bad++; $display("FAIL point_beats got=%0d want=2", beats.size());
    end else begin
      n_cmp++; if (beats[0].addr !== 31'h80A00) begin n_bad++; $display("FAIL point_addr got=%h want=80a00", beats[0].addr); end
      n_cmp++; if (beats[0].mask !== 16'hFFF0) begin n_bad++; $display("FAIL point_mask1 got=%h want=fff0", beats[0].mask); end
      n_cmp++; if (beats[1].mask !== 16'hFFFF) begin n_bad++; $display("FAIL point_mask2 got=%h want=ffff", beats[1].mask); end
    end
  endtask

  task automatic test_vertical();
    beats.delete();
    start_line(2, 0, 2, 3, 32'h00000FF0, 32'h10400000);
    wait_idle(0, lat, tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL vert_timeout"); end
    n_cmp++;
    if (beats.size() != 8) begin
      n_bad++; $display("FAIL vert_beats got=%0d want=8", beats.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (beats[2*i].addr !== AW'(32'h80000 + i * 32'h200)) begin n_bad++; $display("FAIL vert_addr burst=%0d got=%h want=%h", i, beats[2*i].addr, 32'h80000 + i * 32'h200); end
        n_cmp++; if (beats[2*i].mask !== 16'hFF0F || beats[2*i+1].mask !== 16'hFFFF) begin n_bad++; $display("FAIL vert_mask burst=%0d got=%h/%h want=ff0f/ffff", i, beats[2*i].mask, beats[2*i+1].mask); end
      end
    end
  endtask

  task automatic test_backpressure();
    int seen;
    seen = 0;
    beats.delete();
    af_full = 1;
    start_line(0, 0, 7, 0, 32'h00FF0000, 32'h10400000);
    // SETUP + 8 PLOT cycles, then 5 stalled SEND1 cycles
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (af_wr_en || wdf_wr_en) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL bp_af_full_writes got=%0d want=0", seen); end
    @(posedge clk); #1 af_full = 0;
    @(negedge clk);
    n_cmp++; if (af_wr_en !== 1'b1 || wdf_wr_en !== 1'b1 || af_addr_din !== 31'h80000) begin n_bad++; $display("FAIL bp_beat1 got=%b%b addr=%h want=11 80000", af_wr_en, wdf_wr_en, af_addr_din); end
    @(posedge clk); #1 wdf_full = 1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (wdf_wr_en || af_wr_en || wdf_mask_din !== 16'h0000) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL bp_send2_hold got=%0d bad cycles want=0", seen); end
    @(posedge clk); #1 wdf_full = 0;
    @(negedge clk);
    n_cmp++; if (wdf_wr_en !== 1'b1 || af_wr_en !== 1'b0 || wdf_mask_din !== 16'h0000) begin n_bad++; $display("FAIL bp_beat2 got=%b%b mask=%h want=01 0000", af_wr_en, wdf_wr_en, wdf_mask_din); end
    wait_idle(0, lat, tmo);
    n_cmp++; if (tmo || beats.size() != 2) begin n_bad++; $display("FAIL bp_total_beats got=%0d want=2", beats.size()); end
  endtask

  task automatic test_reset_mid_burst();
    int cyc, writes;
    cyc = 0; writes = 0;
    beats.delete();
    start_line(2, 0, 2, 3, 32'h12345678, 32'h10400000);
    do begin @(negedge clk); cyc++; end while (!(wdf_wr_en && !af_wr_en) && cyc < 100);
    n_cmp++; if (cyc >= 100) begin n_bad++; $display("FAIL rstmid_no_send2 got=timeout want=send2"); end
    rst = 1;
    @(negedge clk);
    n_cmp++; if (LE_ready !== 1'b1 || af_wr_en !== 1'b0 || wdf_wr_en !== 1'b0 || wdf_mask_din !== 16'hFFFF) begin
      n_bad++; $display("FAIL rstmid_state got=rdy%b wr%b%b mask=%h want=rdy1 wr00 ffff", LE_ready, af_wr_en, wdf_wr_en, wdf_mask_din);
    end
    @(posedge clk); #1 rst = 0;
    repeat (20) begin
      @(negedge clk);
      if (af_wr_en || wdf_wr_en || !LE_ready) writes++;
    end
    n_cmp++; if (writes != 0) begin n_bad++; $display("FAIL rstmid_quiet got=%0d active cycles want=0", writes); end
    n_cmp++; if (beats.size() != 2) begin n_bad++; $display("FAIL rstmid_beats got=%0d want=2", beats.size()); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int x0, y0, x1, y1, hi;
      logic [31:0] col, base;
      hi = (n % 8 == 0) ? (2**CW - 1) : 40;
      x0 = $urandom_range(0, hi); y0 = $urandom_range(0, hi);
      x1 = $urandom_range(0, hi); y1 = $urandom_range(0, hi);
      if (n % 9 == 4) begin x1 = x0; y1 = y0; end
      if (n % 7 == 3) x1 = x0;
      col = $urandom; base = $urandom;
      model_line(x0, y0, x1, y1, base);
      beats.delete(); af_only = 0;
      start_line(x0, y0, x1, y1, col, base);
      wait_idle(n % 2 == 1, lat, tmo);
      n_cmp++;
      if (tmo || af_only != 0 || beats.size() != 2 * exp_q.size()) begin
        n_bad++;
        $display("FAIL rand_count line=%0d (%0d,%0d)-(%0d,%0d) got=%0d beats tmo=%0d af_only=%0d want=%0d beats",
                 n, x0, y0, x1, y1, beats.size(), tmo, af_only, 2 * exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_cmp++; if (beats[2*i].first !== 1'b1 || beats[2*i+1].first !== 1'b0) begin n_bad++; $display("FAIL rand_beat_order line=%0d burst=%0d got=%b%b want=10", n, i, beats[2*i].first, beats[2*i+1].first); end
          n_cmp++; if (beats[2*i].addr !== exp_q[i].addr) begin n_bad++; $display("FAIL rand_addr line=%0d burst=%0d got=%h want=%h", n, i, beats[2*i].addr, exp_q[i].addr); end
          n_cmp++; if (beats[2*i].mask !== exp_q[i].m1) begin n_bad++; $display("FAIL rand_mask1 line=%0d burst=%0d got=%h want=%h", n, i, beats[2*i].mask, exp_q[i].m1); end
          n_cmp++; if (beats[2*i+1].mask !== exp_q[i].m2) begin n_bad++; $display("FAIL rand_mask2 line=%0d burst=%0d got=%h want=%h", n, i, beats[2*i+1].mask, exp_q[i].m2); end
          n_cmp++; if (beats[2*i].din !== {4{col}} || beats[2*i+1].din !== {4{col}}) begin n_bad++; $display("FAIL rand_data line=%0d burst=%0d got=%h want=%h", n, i, beats[2*i].din, {4{col}}); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal(0);
    test_horizontal(1);
    test_point();
    test_vertical();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_draw_engine.md
LINE_DRAW_ENGINE -- requirements
Module: line_draw_engine

Interface
REQ-001 Parameter COORD_W, default 10, coordinate width in bits; legal range 4..11.
REQ-002 Parameter ADDR_W, default 31, address FIFO word width.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 LE_ready  out  1  high only in IDLE.
REQ-006 LE_color  in  32  pixel colour {8'h0,R,G,B}.
REQ-007 LE_point  in  COORD_W  coordinate value for the asserted valid strobe.
REQ-008 LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid  in  1 each  load strobes.
REQ-009 LE_frame_base  in  32  frame byte base address.
REQ-010 LE_trigger  in  1  start drawing.
REQ-011 af_full, wdf_full  in  1 each  address / write-data FIFO full.
REQ-012 af_addr_din  out  ADDR_W, af_wr_en  out  1  address FIFO write.
REQ-013 wdf_din  out  128, wdf_mask_din  out  16, wdf_wr_en  out  1  write-data FIFO write; mask bit 1 = byte not written.

Function
REQ-014 In IDLE, each strobe shall load its register from LE_point/LE_color at the clock edge; strobes outside IDLE shall be ignored.
REQ-015 LE_trigger in IDLE shall move to SETUP and latch LE_frame_base; values strobed in the trigger cycle shall be used; trigger outside IDLE shall be ignored.
REQ-016 States: IDLE, SETUP, PLOT, SEND1, SEND2.
REQ-017 SETUP (1 cycle) shall register: steep = |y1-y0| > |x1-x0|; endpoints swapped (x<->y if steep, then ordered so nx0 <= nx1); dx = nx1-nx0; dy = |ny1-ny0|; ystep = +1/-1; error = dx>>1 (signed, COORD_W+1 bits); x=nx0, y=ny0; pixel mask cleared; then go to PLOT.
REQ-018 Memory column = steep ? y : x; memory row = steep ? x : y.
REQ-019 Block address = zero-extend to ADDR_W of {frame_base[27:22], row, col[COORD_W-1:3], 2'b00}.
REQ-020 PLOT shall set pixel-mask bit col[2:0] for the current pixel and hold that pixel's block address in a register.
REQ-021 PLOT: if x == nx1, go to SEND1 with last=1; else step (error -= dy; if negative, y += ystep and error += dx; x += 1), staying in PLOT when the next pixel has the same block address, else going to SEND1 with last=0.
REQ-022 Coalescing: all consecutive pixels in one 8-pixel block shall be emitted in a single two-beat burst.
REQ-023 SEND1: af_wr_en = wdf_wr_en = 1 only when ~af_full && ~wdf_full; advance to SEND2 only on that cycle; else hold all outputs and state.
REQ-024 SEND2: wdf_wr_en = 1 only when ~wdf_full; then go to IDLE if last, else to PLOT with the pixel mask cleared.
REQ-025 wdf_din = {4{colour}} in both beats.
REQ-026 Pixel k occupies 32-bit mask bits [31-4k -: 4]; beat 1 mask = ~bits[31:16] (pixels 0-3); beat 2 mask = ~bits[15:0] (pixels 4-7).
REQ-027 wdf_mask_din = 16'hFFFF and both wr_en = 0 outside SEND1/SEND2.
REQ-028 A single-point line (x0==x1, y0==y1) shall produce exactly one burst.
REQ-029 Latency trigger -> first af_wr_en = 3 cycles (IDLE->SETUP->PLOT->SEND1) with FIFOs not full.

Reset
REQ-030 rst shall force IDLE in the next cycle from any state, including mid-burst, and clear all coordinate, colour, frame-base, error and mask registers to 0.
REQ-031 During and after reset: af_wr_en = wdf_wr_en = 0, wdf_mask_din = 16'hFFFF, LE_ready = 1.

Structure
REQ-032 A shared package shall hold the state encoding, the 2'b00 address pad and the 6-bit frame-field slice bounds.
REQ-033 Endpoint swap/steep/delta logic shall be one combinational sub-module, line_setup_calc, with its outputs registered in SETUP.

Verification
REQ-034 Base 0x10400000, colour 0x00FF0000, (0,0)-(7,0) -> one burst, addr 0x80000, masks 0x0000/0x0000, wdf_din = 4x 0x00FF0000.
REQ-035 (7,0)-(0,0) -> identical to REQ-034.
REQ-036 Point (3,5) -> one burst, addr 0x80A00, masks 0xFFF0/0xFFFF.
REQ-037 (2,0)-(2,3) -> four bursts, addrs 0x80000, 0x80200, 0x80400, 0x80600, each with masks 0xFF0F/0xFFFF.
REQ-038 REQ-034 with af_full held high for 5 cycles entering SEND1 -> no wr_en for those cycles, then a correct burst; wdf_full high in SEND2 -> SEND2 held.
REQ-039 rst asserted in SEND2 of a multi-burst line -> next cycle IDLE, LE_ready=1, no further FIFO writes.
